// File: rtl/gf16_pkg.sv
// Shared types, constants and pure GF(2^16) arithmetic helpers for the
// polynomial-multiplier coefficient datapath.
package gf16_pkg;

  localparam int W     = 16;
  localparam int LANES = 9;
  localparam int PW    = 2 * W - 1;
  localparam int LAT   = 3;

  // Field polynomial x^16+x^5+x^3+x^2+1 with the x^16 term implied.
  localparam logic [W-1:0] POLY_DEF = 16'h002D;

  // Index 0 carries the x^15 coefficient, so the numeric value is the usual
  // polynomial encoding (LSB = x^0).
  typedef logic [0:W-1]  coef_t;
  typedef logic [PW-1:0] prod_t;

  function automatic prod_t clmul16(input coef_t a, input coef_t b);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    prod_t        p;
    av = a;
    bv = b;
    p  = '0;
    for (int k = 0; k < W; k++) begin
      if (bv[k]) begin
        p = p ^ (prod_t'(av) << k);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Folding top-down keeps each fold's spill (at most x^(n+5)) below the
  // bits still to be visited.
  function automatic coef_t red16(input prod_t p_in, input logic [W-1:0] poly);
    prod_t p;
    p = p_in;
    for (int n = W - 2; n >= 0; n--) begin
      if (p[W+n]) begin
        p = p ^ (prod_t'(poly) << n);
      end else begin
        p = p;
      end
    end
    return coef_t'(p[W-1:0]);
  endfunction

endpackage

// File: rtl/gf16_mul_lane.sv
// One coefficient lane: S2 registers the carry-less product, S3 registers
// the reduced GF(2^16) result.
module gf16_mul_lane
  import gf16_pkg::*;
#(
  parameter logic [W-1:0] POLY = POLY_DEF
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [0:W-1] o_i,
  input  logic [0:W-1] t_i,
  output logic [0:W-1] r_o
);

  prod_t prod_d;
  prod_t prod_q;
  coef_t res_d;
  coef_t res_q;

  // Next-state: multiply the S1 operands, reduce the S2 product.
  always_comb begin
    prod_d = clmul16(o_i, t_i);
    res_d  = red16(prod_q, POLY);
  end

  // S2/S3 pipeline registers, flushed by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prod_q <= '0;
      res_q  <= '0;
    end else begin
      prod_q <= prod_d;
      res_q  <= res_d;
    end
  end

  assign r_o = res_q;

endmodule

// File: rtl/gf16_mul_array.sv
// Nine-lane GF(2^16) coefficient multiplier with a fixed 3-cycle latency and
// a broadcast scalar operand; outputs come straight from the S3 registers.
module gf16_mul_array
  import gf16_pkg::*;
#(
  parameter logic [W-1:0] POLY = POLY_DEF
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [0:W-1] mul1_o_in,
  input  logic [0:W-1] mul2_o_in,
  input  logic [0:W-1] mul3_o_in,
  input  logic [0:W-1] mul4_o_in,
  input  logic [0:W-1] mul5_o_in,
  input  logic [0:W-1] mul6_o_in,
  input  logic [0:W-1] mul7_o_in,
  input  logic [0:W-1] mul8_o_in,
  input  logic [0:W-1] mul9_o_in,
  input  logic [0:W-1] mul_t_in,
  input  logic         in_vld,
  output logic [0:W-1] mul1_r_dat,
  output logic [0:W-1] mul2_r_dat,
  output logic [0:W-1] mul3_r_dat,
  output logic [0:W-1] mul4_r_dat,
  output logic [0:W-1] mul5_r_dat,
  output logic [0:W-1] mul6_r_dat,
  output logic [0:W-1] mul7_r_dat,
  output logic [0:W-1] mul8_r_dat,
  output logic [0:W-1] mul9_r_dat,
  output logic         out_vld
);

  coef_t          o_d [LANES];
  coef_t          o_q [LANES];
  coef_t          t_d;
  coef_t          t_q;
  coef_t          r_s [LANES];
  logic [LAT-1:0] vld_d;
  logic [LAT-1:0] vld_q;

  // Gather lane operands and advance the valid tag one stage per cycle.
  always_comb begin
    o_d[0] = mul1_o_in;
    o_d[1] = mul2_o_in;
    o_d[2] = mul3_o_in;
    o_d[3] = mul4_o_in;
    o_d[4] = mul5_o_in;
    o_d[5] = mul6_o_in;
    o_d[6] = mul7_o_in;
    o_d[7] = mul8_o_in;
    o_d[8] = mul9_o_in;
    t_d    = mul_t_in;
    vld_d  = {vld_q[LAT-2:0], in_vld};
  end

  // S1 operand registers plus the whole valid chain.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < LANES; i++) begin
        o_q[i] <= '0;
      end
      t_q   <= '0;
      vld_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        o_q[i] <= o_d[i];
      end
      t_q   <= t_d;
      vld_q <= vld_d;
    end
  end

  // Every lane reads the same S1 copy of t, keeping lanes time-coherent.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    gf16_mul_lane #(
      .POLY (POLY)
    ) u_lane (
      .clk   (clk),
      .rst_b (rst_b),
      .o_i   (o_q[g]),
      .t_i   (t_q),
      .r_o   (r_s[g])
    );
  end

  assign mul1_r_dat = r_s[0];
  assign mul2_r_dat = r_s[1];
  assign mul3_r_dat = r_s[2];
  assign mul4_r_dat = r_s[3];
  assign mul5_r_dat = r_s[4];
  assign mul6_r_dat = r_s[5];
  assign mul7_r_dat = r_s[6];
  assign mul8_r_dat = r_s[7];
  assign mul9_r_dat = r_s[8];
  assign out_vld    = vld_q[LAT-1];

endmodule

// File: tb/tb_gf16_mul_array.sv
// Self-checking bench for gf16_mul_array; the reference is a shift-and-reduce
// GF(2^16) multiplier written independently of the RTL helpers.
module tb_gf16_mul_array;

  localparam int NB2B = 200;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        in_vld = 1'b0;
  logic [0:15] o_s [9];
  logic [0:15] t_s = 16'h0000;
  logic [0:15] r_s [9];
  logic        out_vld;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [15:0] bt_o [NB2B][9];
  logic [15:0] bt_t [NB2B];
  logic        bt_v [NB2B];

  always #5 clk = ~clk;

  gf16_mul_array dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .mul1_o_in  (o_s[0]),
    .mul2_o_in  (o_s[1]),
    .mul3_o_in  (o_s[2]),
    .mul4_o_in  (o_s[3]),
    .mul5_o_in  (o_s[4]),
    .mul6_o_in  (o_s[5]),
    .mul7_o_in  (o_s[6]),
    .mul8_o_in  (o_s[7]),
    .mul9_o_in  (o_s[8]),
    .mul_t_in   (t_s),
    .in_vld     (in_vld),
    .mul1_r_dat (r_s[0]),
    .mul2_r_dat (r_s[1]),
    .mul3_r_dat (r_s[2]),
    .mul4_r_dat (r_s[3]),
    .mul5_r_dat (r_s[4]),
    .mul6_r_dat (r_s[5]),
    .mul7_r_dat (r_s[6]),
    .mul8_r_dat (r_s[7]),
    .mul9_r_dat (r_s[8]),
    .out_vld    (out_vld)
  );

  // Reference: multiply by x with immediate reduction, accumulate per t bit.
  function automatic logic [15:0] gmul(input logic [15:0] a_in, input logic [15:0] b_in);
    logic [15:0] a;
    logic [15:0] r;
    a = a_in;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (b_in[i]) r = r ^ a;
      a = a[15] ? ((a << 1) ^ 16'h002D) : (a << 1);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_zero();
    in_vld = 1'b0;
    t_s    = 16'h0000;
    for (int k = 0; k < 9; k++) o_s[k] = 16'h0000;
  endtask

  task automatic test_reset();
    rst_b  = 1'b0;
    in_vld = 1'b1;
    t_s    = 16'($urandom_range(1, 65535));
    for (int k = 0; k < 9; k++) o_s[k] = 16'($urandom_range(1, 65535));
    repeat (5) step();
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (r_s[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_hold lane%0d: got %h expected 0000", k + 1, r_s[k]);
      end
    end
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold out_vld: got %b expected 0", out_vld);
    end
    drive_zero();
    rst_b = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int k = 0; k < 9; k++) begin
        n_checks++;
        if (r_s[k] !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_release c%0d lane%0d: got %h expected 0000", c, k + 1, r_s[k]);
        end
      end
      n_checks++;
      if (out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release c%0d out_vld: got %b expected 0", c, out_vld);
      end
    end
  endtask

  task automatic test_identity();
    logic [0:15] one;
    one    = 16'h0001;
    t_s    = 16'h0001;
    in_vld = 1'b1;
    for (int k = 0; k < 9; k++) o_s[k] = one << k;
    step();
    drive_zero();
    step();
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL identity_early out_vld: got %b expected 0", out_vld);
    end
    step();
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (r_s[k] !== (one << k)) begin
        n_fail++;
        $display("FAIL identity lane%0d: got %h expected %h", k + 1, r_s[k], one << k);
      end
    end
    n_checks++;
    if (out_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL identity out_vld: got %b expected 1", out_vld);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL identity_pulse c%0d out_vld: got %b expected 0", c, out_vld);
      end
    end
  endtask

  // Drives nsets sets back-to-back; focus lane of each set checked against a constant.
  task automatic run_sets(input string name, input int nsets,
                          input logic [15:0] tt [4], input logic [15:0] oo [4],
                          input int lane [4], input logic [15:0] ex [4]);
    logic [15:0] ho [4][9];
    logic [15:0] m;
    for (int c = 0; c < nsets + 3; c++) begin
      if (c >= 3) begin
        for (int k = 0; k < 9; k++) begin
          m = (k == lane[c-3]) ? ex[c-3] : gmul(ho[c-3][k], tt[c-3]);
          n_checks++;
          if (r_s[k] !== m) begin
            n_fail++;
            $display("FAIL %s set%0d lane%0d: got %h expected %h", name, c - 3, k + 1, r_s[k], m);
          end
        end
        n_checks++;
        if (out_vld !== 1'b1) begin
          n_fail++;
          $display("FAIL %s set%0d out_vld: got %b expected 1", name, c - 3, out_vld);
        end
      end
      if (c < nsets) begin
        in_vld = 1'b1;
        t_s    = tt[c];
        for (int k = 0; k < 9; k++) begin
          ho[c][k] = (k == lane[c]) ? oo[c] : 16'($urandom);
          o_s[k]   = ho[c][k];
        end
      end else begin
        drive_zero();
      end
      step();
    end
  endtask

  task automatic test_reduction();
    logic [15:0] tt [4] = '{16'h0002, 16'h0004, 16'h0003, 16'h0000};
    logic [15:0] oo [4] = '{16'h8000, 16'h8000, 16'h0003, 16'h0000};
    int          ln [4] = '{0, 1, 2, 0};
    logic [15:0] ex [4] = '{16'h002D, 16'h005A, 16'h0005, 16'h0000};
    run_sets("reduction", 3, tt, oo, ln, ex);
  endtask

  task automatic test_zero_full();
    logic [15:0] tt [4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] oo [4];
    int          ln [4] = '{0, 0, 0, 0};
    logic [15:0] ex [4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    logic [15:0] ho [2][9];
    oo = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    for (int s = 0; s < 2; s++) begin
      in_vld = 1'b1;
      t_s    = tt[s];
      for (int k = 0; k < 9; k++) o_s[k] = oo[s];
      step();
    end
    drive_zero();
    step();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 9; k++) begin
        n_checks++;
        if (r_s[k] !== ex[s]) begin
          n_fail++;
          $display("FAIL zero_full set%0d lane%0d: got %h expected %h", s, k + 1, r_s[k], ex[s]);
        end
      end
      step();
    end
    ho[0][0] = 16'h0000;
    ln[0]    = ho[0][0] == 16'h0000 ? 0 : 1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] m;
    for (int c = 0; c < NB2B + 3; c++) begin
      if (c >= 3) begin
        for (int k = 0; k < 9; k++) begin
          m = gmul(bt_o[c-3][k], bt_t[c-3]);
          n_checks++;
          if (r_s[k] !== m) begin
            n_fail++;
            $display("FAIL b2b set%0d lane%0d: got %h expected %h", c - 3, k + 1, r_s[k], m);
          end
        end
        n_checks++;
        if (out_vld !== bt_v[c-3]) begin
          n_fail++;
          $display("FAIL b2b set%0d out_vld: got %b expected %b", c - 3, out_vld, bt_v[c-3]);
        end
      end
      if (c < NB2B) begin
        bt_t[c] = 16'($urandom);
        bt_v[c] = ($urandom_range(0, 7) != 0);
        t_s     = bt_t[c];
        in_vld  = bt_v[c];
        for (int k = 0; k < 9; k++) begin
          bt_o[c][k] = 16'($urandom);
          o_s[k]     = bt_o[c][k];
        end
      end else begin
        drive_zero();
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] no [9];
    logic [15:0] nt;
    in_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      t_s = 16'($urandom_range(1, 65535));
      for (int k = 0; k < 9; k++) o_s[k] = 16'($urandom_range(1, 65535));
      step();
    end
    n_checks++;
    if (out_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre out_vld: got %b expected 1", out_vld);
    end
    #2 rst_b = 1'b0;
    #1;
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (r_s[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL midreset_async lane%0d: got %h expected 0000", k + 1, r_s[k]);
      end
    end
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async out_vld: got %b expected 0", out_vld);
    end
    @(negedge clk);
    step();
    drive_zero();
    rst_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 9; k++) begin
        n_checks++;
        if (r_s[k] !== 16'h0000) begin
          n_fail++;
          $display("FAIL midreset_stale c%0d lane%0d: got %h expected 0000", c, k + 1, r_s[k]);
        end
      end
      n_checks++;
      if (out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_stale c%0d out_vld: got %b expected 0", c, out_vld);
      end
    end
    nt     = 16'($urandom_range(1, 65535));
    t_s    = nt;
    in_vld = 1'b1;
    for (int k = 0; k < 9; k++) begin
      no[k]  = 16'($urandom_range(1, 65535));
      o_s[k] = no[k];
    end
    step();
    drive_zero();
    step();
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_early out_vld: got %b expected 0", out_vld);
    end
    step();
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (r_s[k] !== gmul(no[k], nt)) begin
        n_fail++;
        $display("FAIL midreset_next lane%0d: got %h expected %h", k + 1, r_s[k], gmul(no[k], nt));
      end
    end
    n_checks++;
    if (out_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_next out_vld: got %b expected 1", out_vld);
    end
  endtask

  initial begin
    for (int k = 0; k < 9; k++) o_s[k] = 16'h0000;
    test_reset();
    test_identity();
    test_reduction();
    test_zero_full();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
